// File: rtl/sram_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_responder_pkg
//  Desc     : Field layout, type/test codes and length helpers shared by the
//             SRAM memory responder and its response buffer.
//  Revision : 1.0  initial release
// ============================================================================
package sram_mem_responder_pkg;

    // Field widths common to request and response messages
    localparam int c_data_nbits = 32;
    localparam int c_addr_nbits = 32;
    localparam int c_len_nbits  = 2;
    localparam int c_type_nbits = 3;
    localparam int c_test_nbits = 2;

    // Bit offsets of the fields below the opaque field (opaque width is a
    // top-level parameter, so the type field offset is derived there)
    localparam int c_data_lsb        = 0;
    localparam int c_len_lsb         = 32;
    localparam int c_req_addr_lsb    = 34;
    localparam int c_req_opaque_lsb  = 66;
    localparam int c_resp_test_lsb   = 34;
    localparam int c_resp_opaque_lsb = 36;

    typedef enum logic [2:0] {
        MEM_READ  = 3'd0,
        MEM_WRITE = 3'd1,
        MEM_INIT  = 3'd2
    } mem_type_e;

    typedef enum logic [1:0] {
        TEST_OK       = 2'b00,
        TEST_MISALIGN = 2'b01,
        TEST_UNSUPP   = 2'b10
    } mem_test_e;

    // len encodes the byte count with 0 meaning a full word
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

    // Byte-lane mask for a transfer starting at lane 0
    function automatic logic [3:0] len_to_mask(input logic [1:0] len);
        logic [3:0] m;
        case (len)
            2'd1:    m = 4'b0001;
            2'd2:    m = 4'b0011;
            2'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Expand a byte-lane mask to a 32-bit bit mask
    function automatic logic [31:0] mask_to_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_mem_resp_buf.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_resp_buf
//  Desc     : Two-entry response FIFO with bypass. When empty and the sink is
//             ready, the incoming message goes straight through; otherwise it
//             is queued. Exposes its occupancy for upstream flow control.
//  Revision : 1.0  initial release
// ============================================================================
module sram_mem_resp_buf #(
    parameter int MSG_NBITS = 47
) (
    input  logic                 clk,
    input  logic                 reset,      // async, active-low
    input  logic                 enq_val_i,
    input  logic [MSG_NBITS-1:0] enq_msg_i,
    output logic                 deq_val_o,
    input  logic                 deq_rdy_i,
    output logic [MSG_NBITS-1:0] deq_msg_o,
    output logic [1:0]           count_o
);

    logic [MSG_NBITS-1:0] entry_q [2];
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           count_q,  count_d;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty   = (count_q == 2'd0);
    assign deq_val_o = !w_empty || enq_val_i;
    assign deq_msg_o = w_empty ? enq_msg_i : entry_q[rd_ptr_q];
    assign count_o   = count_q;

    // Incoming message is stored unless it bypasses straight to the sink
    assign w_push = enq_val_i && !(w_empty && deq_rdy_i);
    assign w_pop  = !w_empty && deq_rdy_i;

    // Next pointer and occupancy values
    always_comb begin
        rd_ptr_d = rd_ptr_q ^ w_pop;
        wr_ptr_d = wr_ptr_q ^ w_push;
        count_d  = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    // Pointer, count and storage registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (w_push) begin
                entry_q[wr_ptr_q] <= enq_msg_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_responder
//  Desc     : Single-port word memory answering memreq/memresp val/rdy
//             traffic. Array access happens at the accept edge, the formed
//             response is held in stage S1 and then drained through a
//             two-entry bypass buffer, giving one-cycle latency and full
//             throughput while tolerating response back-pressure.
//  Revision : 1.0  initial release
// ============================================================================
module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter int p_mem_nwords   = 256,
    parameter int p_opaque_nbits = 8
) (
    input  logic                        clk,
    input  logic                        reset,        // async, active-low
    input  logic                        memreq_val,
    output logic                        memreq_rdy,
    input  logic [p_opaque_nbits+68:0]  memreq_msg,
    output logic                        memresp_val,
    input  logic                        memresp_rdy,
    output logic [p_opaque_nbits+38:0]  memresp_msg
);

    localparam int c_idx_nbits     = $clog2(p_mem_nwords);
    localparam int c_resp_nbits    = p_opaque_nbits + 39;
    localparam int c_req_type_lsb  = c_req_opaque_lsb + p_opaque_nbits;
    localparam int c_addr_hi_lsb   = c_req_addr_lsb + 2 + c_idx_nbits;

    // Word storage; contents survive reset and start undefined
    logic [31:0] mem_q [p_mem_nwords];

    logic                      s1_val_q, s1_val_d;
    logic [c_resp_nbits-1:0]   s1_msg_q, s1_msg_d;
    logic                      rdy_en_q;

    logic [2:0]                w_type;
    logic [p_opaque_nbits-1:0] w_opaque;
    logic [1:0]                w_len;
    logic [1:0]                w_off;
    logic [c_idx_nbits-1:0]    w_idx;
    logic [31:0]               w_wdata;
    logic                      w_unused_addr_hi;

    logic [2:0]                w_bytes;
    logic                      w_misalign;
    logic [3:0]                w_lane_mask;
    logic [4:0]                w_shamt;
    logic                      w_is_rd;
    logic                      w_is_wr;
    logic                      w_accept;
    logic                      w_do_write;
    logic [31:0]               w_rword;
    logic [31:0]               w_rdata;
    logic [31:0]               w_wdata_sh;
    logic [1:0]                w_test;
    logic [31:0]               w_resp_data;
    logic [c_resp_nbits-1:0]   w_resp;
    logic [1:0]                w_buf_count;
    logic [1:0]                w_occ;

    // Request field extraction; address bits above the index alias
    assign w_type    = memreq_msg[c_req_type_lsb +: c_type_nbits];
    assign w_opaque  = memreq_msg[c_req_opaque_lsb +: p_opaque_nbits];
    assign w_len     = memreq_msg[c_len_lsb +: c_len_nbits];
    assign w_off     = memreq_msg[c_req_addr_lsb +: 2];
    assign w_idx     = memreq_msg[c_req_addr_lsb + 2 +: c_idx_nbits];
    assign w_wdata   = memreq_msg[c_data_lsb +: c_data_nbits];
    assign w_unused_addr_hi = ^memreq_msg[c_req_opaque_lsb-1:c_addr_hi_lsb];

    assign w_bytes     = len_to_bytes(w_len);
    assign w_misalign  = ({2'b00, w_off} + {1'b0, w_bytes}) > 4'd4;
    assign w_lane_mask = len_to_mask(w_len) << w_off;
    assign w_shamt     = {w_off, 3'b000};

    assign w_is_rd    = (w_type == MEM_READ);
    assign w_is_wr    = (w_type == MEM_WRITE) || (w_type == MEM_INIT);
    assign w_accept   = memreq_val && memreq_rdy;
    assign w_do_write = w_accept && w_is_wr && !w_misalign;

    assign w_rword    = mem_q[w_idx];
    assign w_rdata    = (w_rword >> w_shamt) & mask_to_bits(len_to_mask(w_len));
    assign w_wdata_sh = w_wdata << w_shamt;

    // Form the response for the request currently presented
    always_comb begin
        w_test      = TEST_OK;
        w_resp_data = '0;
        if (!(w_is_rd || w_is_wr)) begin
            w_test = TEST_UNSUPP;
        end else if (w_misalign) begin
            w_test = TEST_MISALIGN;
        end else if (w_is_rd) begin
            w_resp_data = w_rdata;
        end
        w_resp = {w_type, w_opaque, w_test, w_len, w_resp_data};
    end

    // S1 is refilled on every accept; otherwise it has drained downstream
    always_comb begin
        s1_val_d = w_accept;
        s1_msg_d = w_accept ? w_resp : s1_msg_q;
    end

    // S1 stage and post-reset ready enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_val_q <= 1'b0;
            s1_msg_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            s1_val_q <= s1_val_d;
            s1_msg_q <= s1_msg_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Byte-masked array write at the accept edge
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lane_mask[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    sram_mem_resp_buf #(
        .MSG_NBITS (c_resp_nbits)
    ) u_resp_buf (
        .clk       (clk),
        .reset     (reset),
        .enq_val_i (s1_val_q),
        .enq_msg_i (s1_msg_q),
        .deq_val_o (memresp_val),
        .deq_rdy_i (memresp_rdy),
        .deq_msg_o (memresp_msg),
        .count_o   (w_buf_count)
    );

    // Outstanding responses held in S1 plus the buffer never exceed two
    assign w_occ      = w_buf_count + {1'b0, s1_val_q};
    assign memreq_rdy = rdy_en_q && (w_occ < 2'd2);

endmodule
`default_nettype wire
